// File: rtl/gate_generator.sv
// gate_generator: programmable one-shot gate for the DDS output window.
// CLK/RSTn, CE qualifies counting, Start/Abort control; Gate/Done/Busy registered.
module gate_generator #(
  parameter int LEAD_W  = 8,
  parameter int WIDTH_W = 16
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               CE,
  input  logic               Start,
  input  logic               Abort,
  input  logic [LEAD_W-1:0]  Lead,
  input  logic [WIDTH_W-1:0] Width,
  output logic               Gate,
  output logic               Done,
  output logic               Busy
);

  localparam int CW = (LEAD_W > WIDTH_W) ? LEAD_W : WIDTH_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEAD   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] wid, wid_n;
  logic          gate_n, done_n;
  logic [CW-1:0] lead_x, width_x;

  assign lead_x  = CW'(Lead);
  assign width_x = CW'(Width);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= IDLE;
      cnt   <= '0;
      wid   <= '0;
      Gate  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      wid   <= wid_n;
      Gate  <= gate_n;
      Done  <= done_n;
    end
  end

  assign Busy = (state != IDLE);

  // cnt == 1 on a CE edge means this edge takes it to zero.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wid_n   = wid;
    gate_n  = Gate;
    done_n  = 1'b0;
    if (Abort) begin
      state_n = IDLE;
      cnt_n   = '0;
      gate_n  = 1'b0;
    end else if (CE) begin
      unique case (state)
        IDLE: begin
          if (Start) begin
            wid_n = width_x;
            if (lead_x != '0) begin
              state_n = LEAD;
              cnt_n   = lead_x;
            end else if (width_x != '0) begin
              state_n = ACTIVE;
              cnt_n   = width_x;
              gate_n  = 1'b1;
            end else begin
              done_n  = 1'b1;
            end
          end
        end
        LEAD: begin
          if (cnt <= CW'(1)) begin
            if (wid != '0) begin
              state_n = ACTIVE;
              cnt_n   = wid;
              gate_n  = 1'b1;
            end else begin
              state_n = IDLE;
              cnt_n   = '0;
              done_n  = 1'b1;
            end
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
        ACTIVE: begin
          if (cnt <= CW'(1)) begin
            state_n = IDLE;
            cnt_n   = '0;
            gate_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          gate_n  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_generator.sv
// tb_gate_generator: directed + random checks of gate_generator
// against an edge-counting reference model.
module tb_gate_generator;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        CE = 1'b0;
  logic        Start = 1'b0;
  logic        Abort = 1'b0;
  logic [7:0]  Lead = '0;
  logic [15:0] Width = '0;
  logic        Gate, Done, Busy;

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_on = 1'b0;

  gate_generator #(.LEAD_W(8), .WIDTH_W(16)) dut (
    .CLK(CLK), .RSTn(RSTn), .CE(CE), .Start(Start), .Abort(Abort),
    .Lead(Lead), .Width(Width), .Gate(Gate), .Done(Done), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a run is k CE edges old; gate is high once k reaches L,
  // and the run ends (done) when k reaches L+W.
  bit m_run, m_gate, m_done;
  int m_k, m_L, m_W;

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      m_run = 0; m_done = 0; m_k = 0; m_L = 0; m_W = 0;
    end else if (Abort) begin
      m_run = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_run) begin
        if (CE) begin
          m_k++;
          if (m_k == m_L + m_W) begin
            m_run = 0; m_done = 1;
          end
        end
      end else if (CE && Start) begin
        m_L = int'(Lead); m_W = int'(Width); m_k = 0;
        if (m_L + m_W == 0) m_done = 1;
        else m_run = 1;
      end
    end
    m_gate = m_run && (m_k >= m_L);
  end

  always @(negedge CLK) begin
    if (cmp_on) begin
      chk("model_gate", int'(Gate), int'(m_gate));
      chk("model_done", int'(Done), int'(m_done));
      chk("model_busy", int'(Busy), int'(m_run));
    end
  end

  int cg, cd, cb;

  task automatic count(input int n, input bit tog);
    cg = 0; cd = 0; cb = 0;
    for (int i = 0; i < n; i++) begin
      if (tog) CE = ~CE;
      @(negedge CLK);
      cg += int'(Gate); cd += int'(Done); cb += int'(Busy);
      @(posedge CLK); #1;
    end
  endtask

  task automatic pulse_start(input int l, input int w);
    Lead = 8'(l); Width = 16'(w); Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0;
  endtask

  initial begin
    cmp_on = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_gate", int'(Gate), 0);
    chk("rst_busy", int'(Busy), 0);
    RSTn = 1'b1; CE = 1'b1;
    count(3, 0);
    chk("idle_busy_cnt", cb, 0);

    pulse_start(3, 5);
    count(12, 0);
    chk("t1_gate_cycles", cg, 5);
    chk("t1_done_cycles", cd, 1);
    chk("t1_busy_cycles", cb, 8);

    pulse_start(0, 1);
    count(4, 0);
    chk("t2a_gate_cycles", cg, 1);
    chk("t2a_done_cycles", cd, 1);
    chk("t2a_busy_cycles", cb, 1);
    pulse_start(0, 0);
    count(4, 0);
    chk("t2b_gate_cycles", cg, 0);
    chk("t2b_done_cycles", cd, 1);
    chk("t2b_busy_cycles", cb, 0);

    pulse_start(2, 4);
    count(16, 1);
    CE = 1'b1;
    chk("t3_gate_cycles", cg, 8);
    chk("t3_done_cycles", cd, 1);
    chk("t3_busy_cycles", cb, 12);
    count(4, 0);

    Lead = 8'd1; Width = 16'd2; Start = 1'b1;
    @(posedge CLK); #1;
    count(12, 0);
    chk("t4_gate_cycles", cg, 6);
    chk("t4_done_cycles", cd, 3);
    chk("t4_busy_cycles", cb, 9);
    Start = 1'b0;
    count(6, 0);
    pulse_start(1, 2);
    Lead = 8'd7; Width = 16'd9;
    count(8, 0);
    chk("t4_latch_gate", cg, 2);
    chk("t4_latch_done", cd, 1);

    pulse_start(0, 10);
    count(3, 0);
    Abort = 1'b1;
    @(posedge CLK); #1;
    Abort = 1'b0;
    chk("abort_gate", int'(Gate), 0);
    chk("abort_busy", int'(Busy), 0);
    count(15, 0);
    chk("abort_done_cycles", cd, 0);
    Lead = 8'd0; Width = 16'd3; Start = 1'b1; Abort = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0; Abort = 1'b0;
    chk("abort_start_busy", int'(Busy), 0);
    chk("abort_start_gate", int'(Gate), 0);
    count(5, 0);
    chk("abort_start_done", cd, 0);

    pulse_start(20, 5);
    count(5, 0);
    chk("lead_busy", int'(Busy), 1);
    #2 RSTn = 1'b0;
    #1;
    chk("async_busy", int'(Busy), 0);
    chk("async_gate", int'(Gate), 0);
    chk("async_done", int'(Done), 0);
    @(posedge CLK); #1;
    RSTn = 1'b1;
    count(30, 0);
    chk("post_rst_activity", cg + cd + cb, 0);

    pulse_start(255, 1000);
    count(1260, 0);
    chk("long_gate_cycles", cg, 1000);
    chk("long_done_cycles", cd, 1);
    chk("long_busy_cycles", cb, 1255);

    for (int i = 0; i < 3000; i++) begin
      CE    = ($urandom_range(0, 9) < 7);
      Start = ($urandom_range(0, 9) < 3);
      Abort = ($urandom_range(0, 99) < 3);
      Lead  = 8'($urandom_range(0, 6));
      Width = 16'($urandom_range(0, 8));
      @(posedge CLK); #1;
    end
    Start = 1'b0; Abort = 1'b0; CE = 1'b1;
    count(20, 0);
    chk("final_idle", int'(Busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
